lrelu_stage: RTL and testbench

LRELU_STAGE -- requirements
Module: lrelu_stage

---
 rtl/lrelu_stage.sv | 189 ++++++++++++++++++
 tb/tb_lrelu_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lrelu_stage.sv
// Two-lane leaky-ReLU stage: start/run/done sequencing, per-lane accept counters, 2-cycle pipeline.
// Optional macro LRELU_STAGE_SAT_EN: saturate the 16-bit result instead of two's-complement wrap.
module lrelu_stage #(
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lr_start_in,
    input  logic [15:0] lr_leak_factor_in,
    input  logic [7:0]  lr_rows_in,
    input  logic [15:0] lr_data_in_1,
    input  logic [15:0] lr_data_in_2,
    input  logic        lr_valid_in_1,
    input  logic        lr_valid_in_2,
    output logic [15:0] lr_data_out_1,
    output logic [15:0] lr_data_out_2,
    output logic        lr_valid_out_1,
    output logic        lr_valid_out_2,
    output logic        lr_busy_out,
    output logic        lr_done_out
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 8;
    localparam int unsigned PW    = 32;
    localparam int unsigned LANES = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Negative inputs are scaled by the Q8.8 leak factor; non-negative pass through.
    function automatic logic signed [PW-1:0] leak_mul(input logic signed [DW-1:0] x,
                                                      input logic signed [DW-1:0] k);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ke;
        logic signed [PW-1:0] p;
        xe = PW'(x);
        ke = PW'(k);
        p  = xe * ke;
        if (x[DW-1]) begin
            return p >>> FRAC_BITS;
        end
        return xe;
    endfunction

    function automatic logic [DW-1:0] reduce16(input logic signed [PW-1:0] v);
`ifdef LRELU_STAGE_SAT_EN
        localparam logic signed [PW-1:0] SAT_MAX = 32'sd32767;
        localparam logic signed [PW-1:0] SAT_MIN = -32'sd32768;
        if (v > SAT_MAX) begin
            return DW'(SAT_MAX);
        end
        if (v < SAT_MIN) begin
            return DW'(SAT_MIN);
        end
        return DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    state_t                  state_q, state_d;
    logic signed [DW-1:0]    leak_q, leak_d;
    logic [CW-1:0]           rows_q, rows_d;
    logic [CW-1:0]           cnt_q    [LANES];
    logic [CW-1:0]           cnt_d    [LANES];
    logic signed [PW-1:0]    s1_val_q [LANES];
    logic signed [PW-1:0]    s1_val_d [LANES];
    logic                    s1_vld_q [LANES];
    logic                    s1_vld_d [LANES];
    logic [DW-1:0]           dout_q   [LANES];
    logic [DW-1:0]           dout_d   [LANES];
    logic                    vout_q   [LANES];
    logic                    vout_d   [LANES];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic signed [DW-1:0]    din      [LANES];
    logic                    vin      [LANES];
    logic                    acc      [LANES];
    logic                    lanes_full;
    logic                    s1_busy;

    // State register and all pipeline/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            leak_q  <= '0;
            rows_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l]    <= '0;
                s1_val_q[l] <= '0;
                s1_vld_q[l] <= 1'b0;
                dout_q[l]   <= '0;
                vout_q[l]   <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            leak_q  <= leak_d;
            rows_q  <= rows_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l]    <= cnt_d[l];
                s1_val_q[l] <= s1_val_d[l];
                s1_vld_q[l] <= s1_vld_d[l];
                dout_q[l]   <= dout_d[l];
                vout_q[l]   <= vout_d[l];
            end
        end
    end

    // Next-state, accept decisions and pipeline next values.
    always_comb begin
        state_d    = state_q;
        leak_d     = leak_q;
        rows_d     = rows_q;
        din[0]     = lr_data_in_1;
        din[1]     = lr_data_in_2;
        vin[0]     = lr_valid_in_1;
        vin[1]     = lr_valid_in_2;
        lanes_full = 1'b1;
        s1_busy    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            cnt_d[l] = cnt_q[l];
            acc[l]   = 1'b0;
            if (cnt_q[l] != rows_q) begin
                lanes_full = 1'b0;
            end
            if (s1_vld_q[l]) begin
                s1_busy = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (lr_start_in) begin
                    state_d = S_RUN;
                    leak_d  = lr_leak_factor_in;
                    rows_d  = lr_rows_in;
                    for (int l = 0; l < LANES; l++) begin
                        cnt_d[l] = '0;
                    end
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    acc[l] = vin[l] && (cnt_q[l] < rows_q);
                    if (acc[l]) begin
                        cnt_d[l] = cnt_q[l] + CW'(1);
                    end
                end
                // Finish once every lane has its quota and stage 1 has drained.
                if (lanes_full && !s1_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int l = 0; l < LANES; l++) begin
            s1_vld_d[l] = acc[l];
            s1_val_d[l] = acc[l] ? leak_mul(din[l], leak_q) : s1_val_q[l];
            vout_d[l]   = s1_vld_q[l];
            dout_d[l]   = s1_vld_q[l] ? reduce16(s1_val_q[l]) : dout_q[l];
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign lr_data_out_1  = dout_q[0];
    assign lr_data_out_2  = dout_q[1];
    assign lr_valid_out_1 = vout_q[0];
    assign lr_valid_out_2 = vout_q[1];
    assign lr_busy_out    = busy_q;
    assign lr_done_out    = done_q;

endmodule

// File: tb/tb_lrelu_stage.sv
// Bench for lrelu_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_lrelu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lr_start_in = 1'b0;
    logic [15:0] lr_leak_factor_in = '0;
    logic [7:0]  lr_rows_in = '0;
    logic [15:0] lr_data_in_1 = '0;
    logic [15:0] lr_data_in_2 = '0;
    logic        lr_valid_in_1 = 1'b0;
    logic        lr_valid_in_2 = 1'b0;
    logic [15:0] lr_data_out_1;
    logic [15:0] lr_data_out_2;
    logic        lr_valid_out_1;
    logic        lr_valid_out_2;
    logic        lr_busy_out;
    logic        lr_done_out;

    int n_chk = 0;
    int n_err = 0;

    lrelu_stage dut (
        .clk               (clk),
        .rst               (rst),
        .lr_start_in       (lr_start_in),
        .lr_leak_factor_in (lr_leak_factor_in),
        .lr_rows_in        (lr_rows_in),
        .lr_data_in_1      (lr_data_in_1),
        .lr_data_in_2      (lr_data_in_2),
        .lr_valid_in_1     (lr_valid_in_1),
        .lr_valid_in_2     (lr_valid_in_2),
        .lr_data_out_1     (lr_data_out_1),
        .lr_data_out_2     (lr_data_out_2),
        .lr_valid_out_1    (lr_valid_out_1),
        .lr_valid_out_2    (lr_valid_out_2),
        .lr_busy_out       (lr_busy_out),
        .lr_done_out       (lr_done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference activation: plain integer arithmetic, then saturate or wrap.
    function automatic logic [15:0] ref_act(input int x, input int k);
        int p;
        logic [31:0] pb;
        if (x >= 0) p = x;
        else        p = (x * k) >>> 8;
`ifdef LRELU_STAGE_SAT_EN
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
`endif
        pb = p;
        return pb[15:0];
    endfunction

    // Model: mode 0 idle, 1 running, 2 done; per-lane queues of (due edge, value).
    int          m_mode = 0;
    int          m_edge = 0;
    int          m_rows = 0;
    int          m_leak = 0;
    int          m_cnt [2] = '{0, 0};
    int          m_last_acc = -100;
    int          due_q [2][$];
    logic [15:0] val_q [2][$];
    logic        m_vout [2] = '{1'b0, 1'b0};
    logic [15:0] m_dout [2] = '{16'h0, 16'h0};
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    bit          model_ok = 1'b0;
    bit          sim_end = 1'b0;

    always @(posedge clk) begin
        int  xin [2];
        bit  vin [2];
        xin[0] = int'($signed(lr_data_in_1));
        xin[1] = int'($signed(lr_data_in_2));
        vin[0] = lr_valid_in_1;
        vin[1] = lr_valid_in_2;
        if (rst) begin
            m_mode = 0; m_rows = 0; m_leak = 0; m_last_acc = -100;
            m_busy = 0; m_done = 0;
            for (int l = 0; l < 2; l++) begin
                m_cnt[l] = 0; m_vout[l] = 0; m_dout[l] = '0;
                due_q[l].delete(); val_q[l].delete();
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                m_vout[l] = 0;
                if (due_q[l].size() > 0 && due_q[l][0] == m_edge) begin
                    m_vout[l] = 1;
                    m_dout[l] = val_q[l].pop_front();
                    void'(due_q[l].pop_front());
                end
            end
            case (m_mode)
                0: if (lr_start_in) begin
                    m_mode = 1;
                    m_leak = int'($signed(lr_leak_factor_in));
                    m_rows = int'(lr_rows_in);
                    m_cnt[0] = 0; m_cnt[1] = 0;
                    m_last_acc = -100;
                end
                1: begin
                    if (m_cnt[0] == m_rows && m_cnt[1] == m_rows && m_last_acc <= m_edge - 2)
                        m_mode = 2;
                    else
                        for (int l = 0; l < 2; l++)
                            if (vin[l] && m_cnt[l] < m_rows) begin
                                due_q[l].push_back(m_edge + 1);
                                val_q[l].push_back(ref_act(xin[l], m_leak));
                                m_cnt[l]++;
                                m_last_acc = m_edge;
                            end
                end
                default: m_mode = 0;
            endcase
            m_busy = (m_mode != 0);
            m_done = (m_mode == 2);
        end
        m_edge++;
        model_ok = 1'b1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok && !sim_end) begin
            chk("m_vout1", lr_valid_out_1, m_vout[0]);
            chk("m_vout2", lr_valid_out_2, m_vout[1]);
            chk("m_dout1", lr_data_out_1, m_dout[0]);
            chk("m_dout2", lr_data_out_2, m_dout[1]);
            chk("m_busy", lr_busy_out, m_busy);
            chk("m_done", lr_done_out, m_done);
        end
    end

    task automatic clear_in();
        lr_start_in = 0; lr_valid_in_1 = 0; lr_valid_in_2 = 0;
    endtask

    // Returns at the first negedge where the block is running.
    task automatic start(input logic [15:0] leak, input logic [7:0] rows);
        @(negedge clk);
        lr_start_in = 1; lr_leak_factor_in = leak; lr_rows_in = rows;
        @(negedge clk);
        lr_start_in = 0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (lr_done_out) seen = 1;
        end
        chk("done_seen", int'(seen), 1);
    endtask

    // Single-row run on both lanes with literal expected outputs and done timing.
    task automatic run1(input logic [15:0] leak, input logic [15:0] x1, input logic [15:0] x2,
                        input logic [15:0] e1, input logic [15:0] e2);
        start(leak, 8'd1);
        lr_valid_in_1 = 1; lr_data_in_1 = x1;
        lr_valid_in_2 = 1; lr_data_in_2 = x2;
        @(negedge clk);
        clear_in();
        @(negedge clk);
        chk("r1_vout1", lr_valid_out_1, 1);
        chk("r1_vout2", lr_valid_out_2, 1);
        chk("r1_dout1", lr_data_out_1, e1);
        chk("r1_dout2", lr_data_out_2, e2);
        @(negedge clk);
        chk("r1_done", lr_done_out, 1);
        chk("r1_vout1_off", lr_valid_out_1, 0);
        chk("r1_dout1_hold", lr_data_out_1, e1);
        @(negedge clk);
        chk("r1_idle", lr_busy_out, 0);
    endtask

    initial begin
        int v1, v2, nd, last_v2, done_c;
        repeat (3) @(negedge clk);
        chk("rst_busy", lr_busy_out, 0);
        chk("rst_vout1", lr_valid_out_1, 0);
        chk("rst_dout2", lr_data_out_2, 0);
        rst = 0;

        // Negative scaled, positive passed, zero, overflow of product.
        run1(16'h0019, 16'hFE00, 16'h0300, 16'hFFCE, 16'h0300);
        run1(16'h0019, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
`ifdef LRELU_STAGE_SAT_EN
        run1(16'h0200, 16'h8000, 16'hFF00, 16'h8000, 16'hFE00);
`else
        run1(16'h0200, 16'h8000, 16'hFF00, 16'h0000, 16'hFE00);
`endif

        // rows=3, lane1 valid cycles 0..2, lane2 cycles 1..4 (last one dropped).
        start(16'h0019, 8'd3);
        v1 = 0; v2 = 0; nd = 0; last_v2 = -1; done_c = -1;
        for (int c = 0; c < 10; c++) begin
            if (lr_valid_out_1) v1++;
            if (lr_valid_out_2) begin v2++; last_v2 = c; end
            if (lr_done_out) begin nd++; done_c = c; end
            lr_valid_in_1 = (c <= 2);
            lr_data_in_1  = 16'((c + 1) * 100);
            lr_valid_in_2 = (c >= 1 && c <= 4);
            lr_data_in_2  = 16'(-256 * c);
            @(negedge clk);
        end
        clear_in();
        chk("r3_v1_count", v1, 3);
        chk("r3_v2_count", v2, 3);
        chk("r3_done_count", nd, 1);
        chk("r3_done_after_last", done_c, last_v2 + 1);
        chk("r3_busy_low", lr_busy_out, 0);

        // rows=0: one RUN cycle then DONE with no output.
        start(16'h0019, 8'd0);
        chk("r0_busy", lr_busy_out, 1);
        chk("r0_no_done", lr_done_out, 0);
        @(negedge clk);
        chk("r0_done", lr_done_out, 1);
        chk("r0_no_vout", lr_valid_out_1, 0);
        @(negedge clk);
        chk("r0_idle", lr_busy_out, 0);

        // Start during RUN must not change the latched leak or rows.
        start(16'h0019, 8'd2);
        lr_start_in = 1; lr_leak_factor_in = 16'h7FFF; lr_rows_in = 8'd9;
        lr_valid_in_1 = 1; lr_data_in_1 = 16'hFE00;
        lr_valid_in_2 = 1; lr_data_in_2 = 16'hFC00;
        @(negedge clk);
        lr_start_in = 0;
        @(negedge clk);
        clear_in();
        chk("ign_dout1", lr_data_out_1, 16'hFFCE);
        chk("ign_dout2", lr_data_out_2, 16'hFF9C);
        wait_done(10);
        @(negedge clk);
        chk("ign_idle", lr_busy_out, 0);

        // Reset with samples in flight.
        start(16'h0019, 8'd3);
        lr_valid_in_1 = 1; lr_data_in_1 = 16'h0100;
        lr_valid_in_2 = 1; lr_data_in_2 = 16'hFE00;
        @(negedge clk);
        @(negedge clk);
        clear_in();
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mr_vout1", lr_valid_out_1, 0);
        chk("mr_vout2", lr_valid_out_2, 0);
        chk("mr_dout1", lr_data_out_1, 0);
        chk("mr_dout2", lr_data_out_2, 0);
        chk("mr_busy", lr_busy_out, 0);
        nd = 0; v1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (lr_done_out) nd++;
            if (lr_valid_out_1 || lr_valid_out_2) v1++;
        end
        chk("mr_quiet_done", nd, 0);
        chk("mr_quiet_valid", v1, 0);

        start(16'h0080, 8'd2);
        for (int c = 0; c < 2; c++) begin
            lr_valid_in_1 = 1; lr_data_in_1 = 16'hFFFC;
            lr_valid_in_2 = 1; lr_data_in_2 = 16'h0006;
            @(negedge clk);
        end
        clear_in();
        chk("mr2_dout1", lr_data_out_1, 16'hFFFE);
        chk("mr2_dout2", lr_data_out_2, 16'h0006);
        wait_done(10);
        @(negedge clk);
        chk("mr2_idle", lr_busy_out, 0);

        sim_end = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
